// File: rtl/sha256_core_job_sequencer.sv
// Initiator-side sequencer for one SHA-256 core: block intake, level-init handshake,
// single-entry digest output register and round-timeout watchdog.
module sha256_core_job_sequencer #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 127,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [511:0]       blk_data,
  input  logic [TAG_W-1:0]   blk_tag,
  output logic               core_init,
  output logic [511:0]       core_block,
  input  logic [255:0]       core_digest,
  input  logic               core_digest_valid,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [255:0]       dig_data,
  output logic [TAG_W-1:0]   dig_tag,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] wd_r;
  logic [TAG_W-1:0] job_tag_r;
  logic             accept_s;
  logic             out_free_s;
  logic             capture_s;
  logic             expire_s;

  assign blk_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);

  // Handshake qualifiers; a done core with a blocked output simply waits in ISSUE.
  always_comb begin
    accept_s   = blk_valid && (state_r == ST_IDLE);
    out_free_s = !dig_valid || dig_ready;
    capture_s  = (state_r == ST_ISSUE) && core_digest_valid && out_free_s;
    expire_s   = (state_r == ST_ISSUE) && !core_digest_valid && (wd_r == WD_LIMIT);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ISSUE;
        else          state_s = state_r;
      end
      ST_ISSUE: begin
        if (capture_s || expire_s) state_s = ST_RELEASE;
        else                       state_s = state_r;
      end
      ST_RELEASE: begin
        if (!core_digest_valid) state_s = ST_IDLE;
        else                    state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; core_init is the registered image of "next state is ISSUE".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      core_init <= 1'b0;
    end else begin
      state_r   <= state_s;
      core_init <= (state_s == ST_ISSUE);
    end
  end

  // Job capture; core_block only moves on accept, so it is stable while init is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_block <= 512'd0;
      job_tag_r  <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      core_block <= blk_data;
      job_tag_r  <= blk_tag;
    end
  end

  // Round watchdog: frozen while the core reports done but the output is blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      wd_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ISSUE) && !core_digest_valid && !expire_s) begin
      wd_r <= wd_r + CNT_W'(1);
    end
  end

  // Single-entry digest register; drain and refill in one cycle leaves no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_valid <= 1'b0;
      dig_data  <= 256'd0;
      dig_tag   <= {TAG_W{1'b0}};
    end else if (capture_s) begin
      dig_valid <= 1'b1;
      dig_data  <= core_digest;
      dig_tag   <= job_tag_r;
    end else if (dig_ready) begin
      dig_valid <= 1'b0;
    end
  end

  // Sticky timeout flag; a coincident expiry beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (expire_s) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_core_job_sequencer.sv
// Directed bench for sha256_core_job_sequencer with a behavioural SHA-256 core model
// (configurable round latency, release hold and non-responding mode).
module tb_sha256_core_job_sequencer;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 127;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               blk_valid = 1'b0;
  logic               blk_ready;
  logic [511:0]       blk_data = 512'd0;
  logic [TAG_W-1:0]   blk_tag = 4'd0;
  logic               core_init;
  logic [511:0]       core_block;
  logic [255:0]       core_digest;
  logic               core_digest_valid;
  logic               dig_valid;
  logic               dig_ready = 1'b0;
  logic [255:0]       dig_data;
  logic [TAG_W-1:0]   dig_tag;
  logic               busy;
  logic               timeout_err;
  logic               err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0] abc_blk = {32'h61626380, 448'd0, 32'h00000018};
  logic [255:0] abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [511:0] blk_a   = {256'h00A5, 256'h000F};
  logic [255:0] dig_a   = 256'h00AA;
  logic [511:0] blk_b   = {256'h1234, 256'h00FF};
  logic [255:0] dig_b   = 256'h12CB;

  // core model controls
  int k_cfg    = 66;
  int hold_cfg = 0;
  bit core_en  = 1'b1;
  int core_cnt;
  int core_hold;
  logic core_done;

  sha256_core_job_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_tag(blk_tag),
    .core_init(core_init), .core_block(core_block),
    .core_digest(core_digest), .core_digest_valid(core_digest_valid),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_tag(dig_tag),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Core model: done K+1 edges after init is first sampled high, holds done while
  // init stays high, then keeps digest_valid for hold_cfg cycles after init drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cnt  <= 0;
      core_hold <= 0;
      core_done <= 1'b0;
    end else if (core_init) begin
      if (core_done) begin
        core_hold <= hold_cfg;
      end else if (core_en && core_cnt == k_cfg) begin
        core_done <= 1'b1;
        core_hold <= hold_cfg;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else begin
      core_cnt <= 0;
      if (core_hold != 0) core_hold <= core_hold - 1;
      else                core_done <= 1'b0;
    end
  end

  assign core_digest_valid = core_done && (core_init || core_hold != 0);
  assign core_digest = (core_block == abc_blk) ? abc_dig
                                               : (core_block[511:256] ^ core_block[255:0]);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block; the tick inside is the accept edge T.
  task automatic send(input logic [511:0] data, input logic [TAG_W-1:0] tag);
    int guard = 0;
    while (!blk_ready && guard < 300) begin
      tick();
      guard++;
    end
    check("send_ready", blk_ready, 1'b1);
    blk_data  = data;
    blk_tag   = tag;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic wait_dig(input int max_cyc, output int n);
    n = 0;
    while (!dig_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check("wait_dig", dig_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int sent;
    int got;
    int last;

    // reset state
    #12;
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_core_init", core_init, 1'b0);
    check("rst_dig_valid", dig_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_block_lo", core_block[255:0], 256'd0);
    check("rst_dig_data", dig_data, 256'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single "abc" job, K=66, output held so the timing is visible
    k_cfg = 66; hold_cfg = 0; dig_ready = 1'b0;
    send(abc_blk, 4'd3);
    check("t1_busy", busy, 1'b1);
    check("t1_blk_ready", blk_ready, 1'b0);
    check("t1_init", core_init, 1'b1);
    check("t1_block_hi", core_block[511:256], abc_blk[511:256]);
    check("t1_block_lo", core_block[255:0], abc_blk[255:0]);
    repeat (67) tick();
    check("t1_valid_early", dig_valid, 1'b0);
    check("t1_init_run", core_init, 1'b1);
    tick();
    check("t1_valid_68", dig_valid, 1'b1);
    check("t1_data", dig_data, abc_dig);
    check("t1_tag", dig_tag, 4'd3);
    check("t1_init_low", core_init, 1'b0);
    tick();
    check("t1_valid_held", dig_valid, 1'b1);
    check("t1_back_idle", blk_ready, 1'b1);
    dig_ready = 1'b1;
    tick();
    check("t1_drained", dig_valid, 1'b0);
    dig_ready = 1'b0;

    // back-pressure: job B finishes while job A is still pending
    k_cfg = 10;
    send(blk_a, 4'd1);
    wait_dig(40, n);
    send(blk_b, 4'd2);
    repeat (150) tick();
    check("t2_held_valid", dig_valid, 1'b1);
    check("t2_held_tag", dig_tag, 4'd1);
    check("t2_held_data", dig_data, dig_a);
    check("t2_init_high", core_init, 1'b1);
    check("t2_busy", busy, 1'b1);
    check("t2_wd_frozen", timeout_err, 1'b0);
    dig_ready = 1'b1;
    tick();
    check("t2_nobubble", dig_valid, 1'b1);
    check("t2_tag_b", dig_tag, 4'd2);
    check("t2_data_b", dig_data, dig_b);
    check("t2_init_rel", core_init, 1'b0);
    tick();
    check("t2_drained", dig_valid, 1'b0);

    // release handshake: core keeps digest_valid 3 cycles after init drops
    k_cfg = 5; hold_cfg = 3;
    send(blk_a, 4'd4);
    wait_dig(20, n);
    check("t3_latency", n, 7);
    check("t3_init_low", core_init, 1'b0);
    check("t3_ready_low0", blk_ready, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_ready_low", blk_ready, 1'b0);
    end
    tick();
    check("t3_ready_back", blk_ready, 1'b1);
    hold_cfg = 0;

    // timeout, with err_clr held high so set must win
    core_en = 1'b0; err_clr = 1'b1;
    send(blk_a, 4'd5);
    repeat (127) tick();
    check("t4_no_err_127", timeout_err, 1'b0);
    check("t4_init_127", core_init, 1'b1);
    tick();
    check("t4_err_128", timeout_err, 1'b1);
    check("t4_init_off", core_init, 1'b0);
    check("t4_no_digest", dig_valid, 1'b0);
    err_clr = 1'b0;
    tick();
    check("t4_sticky", timeout_err, 1'b1);
    check("t4_idle", blk_ready, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_cleared", timeout_err, 1'b0);
    core_en = 1'b1;

    // reset in the middle of a job, with an older digest still pending
    dig_ready = 1'b0; k_cfg = 5;
    send(blk_b, 4'd8);
    wait_dig(20, n);
    k_cfg = 66;
    send(blk_a, 4'd5);
    repeat (30) tick();
    check("t5_pre_init", core_init, 1'b1);
    check("t5_pre_pending", dig_valid, 1'b1);
    reset_n = 1'b0;
    #2;
    check("t5_init", core_init, 1'b0);
    check("t5_dig_valid", dig_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_blk_ready", blk_ready, 1'b1);
    check("t5_dig_tag", dig_tag, 4'd0);
    tick();
    tick();
    reset_n = 1'b1;
    dig_ready = 1'b1;
    send(abc_blk, 4'd9);
    wait_dig(100, n);
    check("t5_latency", n, 68);
    check("t5_tag", dig_tag, 4'd9);
    check("t5_data", dig_data, abc_dig);
    tick();

    // streaming: 8 back-to-back blocks, K=10, period K+4
    k_cfg = 10;
    sent = 0; got = 0; last = 0;
    for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
      if (blk_ready && sent < 8) begin
        blk_data  = {224'd0, 32'(sent), 224'd0, 32'hC0DE0000};
        blk_tag   = sent[3:0];
        blk_valid = 1'b1;
        sent++;
      end else begin
        blk_valid = 1'b0;
      end
      tick();
      if (dig_valid) begin
        check("t6_tag", dig_tag, got[3:0]);
        check("t6_data", dig_data, {224'd0, 32'hC0DE0000 | 32'(got)});
        if (got > 0) check("t6_period", cyc - last, 14);
        last = cyc;
        got++;
      end
    end
    blk_valid = 1'b0;
    check("t6_count", got, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
